// File: rtl/serial_frame_reader.sv
// serial_frame_reader: captures a 1..STRB_MAX strobe frame from LANES serial lines, MSB- or LSB-first, with abort.
// Define READER_TIMEOUT_EN to close a frame early after TIMEOUT_CYCLES idle cycles in READ.
module serial_frame_reader #(
    parameter int MAX_BITS       = 32,
    parameter int LANES          = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int STRB_MAX      = MAX_BITS / LANES,
    localparam int CW            = $clog2(STRB_MAX + 1),
    localparam int BW            = $clog2(MAX_BITS + 1)
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CW-1:0]       frame_len,
    input  logic                lsb_first,
    input  logic                abort,
    input  logic                read_sig,
    input  logic [LANES-1:0]    data_in,
    output logic [MAX_BITS-1:0] data_out,
    output logic [BW-1:0]       bit_count,
    output logic                busy,
    output logic                data_ready,
    output logic                done,
    output logic                timed_out
);
    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
    state_t              state_q;
    logic [CW-1:0]       len_q, cnt_q, cnt_d;
    logic                lsb_q, tmo_q, tmo_hit;
    logic [MAX_BITS-1:0] buf_q, buf_d;
    logic [LANES-1:0]    rev;

    // LSB-first frames OR each strobe into a buffer cleared at start; the earliest lane lands lowest.
    always_comb begin
        for (int j = 0; j < LANES; j++) rev[j] = data_in[LANES-1-j];
        cnt_d = cnt_q + 1'b1;
        buf_d = lsb_q ? (buf_q | (MAX_BITS'(rev) << (cnt_q * LANES)))
                      : ((buf_q << LANES) | MAX_BITS'(data_in));
    end

`ifdef READER_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    logic [GW-1:0] gap_q;
    assign tmo_hit = (state_q == READ) && !read_sig && (gap_q == GW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge sys_clk) begin
        if (rst || state_q != READ || read_sig) gap_q <= '0;
        else gap_q <= gap_q + 1'b1;
    end
`else
    assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            lsb_q      <= 1'b0;
            tmo_q      <= 1'b0;
            buf_q      <= '0;
            data_out   <= '0;
            bit_count  <= '0;
            busy       <= 1'b0;
            data_ready <= 1'b0;
            done       <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        len_q      <= (frame_len == '0 || frame_len > CW'(STRB_MAX)) ? CW'(STRB_MAX) : frame_len;
                        lsb_q      <= lsb_first;
                        buf_q      <= '0;
                        cnt_q      <= '0;
                        tmo_q      <= 1'b0;
                        data_ready <= 1'b0;
                        timed_out  <= 1'b0;
                        state_q    <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end else if (read_sig) begin
                        buf_q <= buf_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == len_q) state_q <= DONE;
                    end else if (tmo_hit) begin
                        tmo_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    data_out   <= buf_q;
                    bit_count  <= BW'(cnt_q * LANES);
                    data_ready <= 1'b1;
                    done       <= 1'b1;
                    timed_out  <= tmo_q;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_reader.sv
// tb_serial_frame_reader: table-driven frames plus hand sequences, scored against expected-result queues.
module tb_serial_frame_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, lsb_first, abort, read_sig, din1;
    logic [5:0]  frame_len;
    logic [3:0]  din4;
    logic [31:0] dout_a, dout_b;
    logic [5:0]  bc_a, bc_b;
    logic        busy_a, rdy_a, done_a, to_a, busy_b, rdy_b, done_b, to_b;

    serial_frame_reader #(.MAX_BITS(32), .LANES(1), .TIMEOUT_CYCLES(16)) ua (
        .sys_clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .lsb_first(lsb_first),
        .abort(abort), .read_sig(read_sig), .data_in(din1), .data_out(dout_a), .bit_count(bc_a),
        .busy(busy_a), .data_ready(rdy_a), .done(done_a), .timed_out(to_a));

    serial_frame_reader #(.MAX_BITS(32), .LANES(4), .TIMEOUT_CYCLES(16)) ub (
        .sys_clk(clk), .rst(rst), .start(start), .frame_len(frame_len[3:0]), .lsb_first(lsb_first),
        .abort(abort), .read_sig(read_sig), .data_in(din4), .data_out(dout_b), .bit_count(bc_b),
        .busy(busy_b), .data_ready(rdy_b), .done(done_b), .timed_out(to_b));

    typedef struct {logic [31:0] data; logic [5:0] cnt; logic to;} exp_t;
    typedef struct {logic [5:0] len; logic lsb; logic [31:0] seq; int n; logic [31:0] data; logic [5:0] cnt;} vec_t;

    exp_t qa[$], qb[$];
    bit   chk_b = 1'b0;
    int   n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (done_a) begin
            if (qa.size() == 0) chk("done_a_unexpected", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_data", dout_a, e.data);
                chk("a_count", 32'(bc_a), 32'(e.cnt));
                chk("a_timeout", 32'(to_a), 32'(e.to));
                chk("a_ready", 32'(rdy_a), 32'd1);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (chk_b && done_b) begin
            if (qb.size() == 0) chk("done_b_unexpected", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_data", dout_b, e.data);
                chk("b_count", 32'(bc_b), 32'(e.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic [5:0] l, input logic lsb);
        frame_len = l;
        lsb_first = lsb;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic strobe1(input logic b);
        read_sig = 1'b1;
        din1 = b;
        step();
        read_sig = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy_a && k < 20) begin
            step();
            k++;
        end
        chk(nm, 32'(busy_a), 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{6'd8,  1'b0, 32'h0000004D, 8,  32'h000000B2, 6'd8};
        tbl[1] = '{6'd8,  1'b1, 32'h0000004D, 8,  32'h0000004D, 6'd8};
        tbl[2] = '{6'd0,  1'b0, 32'hFFFF0000, 32, 32'h0000FFFF, 6'd32};
        tbl[3] = '{6'd40, 1'b1, 32'h000000F1, 32, 32'h000000F1, 6'd32};
        tbl[4] = '{6'd1,  1'b0, 32'h00000001, 1,  32'h00000001, 6'd1};
        tbl[5] = '{6'd5,  1'b0, 32'h00000016, 5,  32'h0000000D, 6'd5};
        tbl[6] = '{6'd3,  1'b1, 32'h00000006, 3,  32'h00000006, 6'd3};

        rst = 1'b1; start = 1'b0; lsb_first = 1'b0; abort = 1'b0; read_sig = 1'b0;
        din1 = 1'b0; din4 = 4'h0; frame_len = 6'd0;
        step();
        step();
        chk("rst_data", dout_a, 32'd0);
        chk("rst_flags", {26'd0, busy_a, rdy_a, done_a, to_a, 2'b00}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            qa.push_back('{tbl[i].data, tbl[i].cnt, 1'b0});
            begin_frame(tbl[i].len, tbl[i].lsb);
            for (int k = 0; k < tbl[i].n; k++) strobe1(tbl[i].seq[k]);
            wait_idle("tbl_idle");
            chk("tbl_ready", 32'(rdy_a), 32'd1);
        end

        // Completion latency around the final strobe
        qa.push_back('{32'hB2, 6'd8, 1'b0});
        begin_frame(6'd8, 1'b0);
        chk("start_clears_ready", 32'(rdy_a), 32'd0);
        for (int k = 0; k < 8; k++) strobe1(tbl[0].seq[k]);
        chk("n_done", {busy_a, done_a}, 32'b10);
        step();
        chk("n1_done", {busy_a, rdy_a, done_a}, 32'b111);
        chk("n1_data", dout_a, 32'hB2);
        step();
        chk("n2_done", {busy_a, rdy_a, done_a}, 32'b010);

        begin_frame(6'd8, 1'b0);
        repeat (3) strobe1(1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_flags", {busy_a, rdy_a, done_a}, 32'b000);
        chk("abort_data", dout_a, 32'hB2);

        begin_frame(6'd8, 1'b0);
        repeat (7) strobe1(1'b0);
        abort = 1'b1; read_sig = 1'b1; din1 = 1'b1;
        step();
        abort = 1'b0; read_sig = 1'b0;
        repeat (3) step();
        chk("abort_read_flags", {busy_a, rdy_a}, 32'b00);
        chk("abort_read_data", dout_a, 32'hB2);

        begin_frame(6'd8, 1'b0);
        repeat (5) strobe1(1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_data", dout_a, 32'd0);
        chk("midrst_flags", {26'd0, busy_a, rdy_a, done_a, to_a, 2'b00}, 32'd0);
        chk("midrst_count", 32'(bc_a), 32'd0);
        qa.push_back('{32'hB2, 6'd8, 1'b0});
        begin_frame(6'd8, 1'b0);
        for (int k = 0; k < 8; k++) strobe1(tbl[0].seq[k]);
        wait_idle("postrst_idle");

        // A start while busy must not restart or relengthen the frame
        qa.push_back('{32'h5, 6'd3, 1'b0});
        begin_frame(6'd3, 1'b0);
        strobe1(1'b1);
        frame_len = 6'd8; start = 1'b1;
        step();
        start = 1'b0;
        strobe1(1'b0);
        strobe1(1'b1);
        wait_idle("busy_start_idle");

        strobe1(1'b1);
        strobe1(1'b1);
        qa.push_back('{32'h1, 6'd2, 1'b0});
        frame_len = 6'd2; lsb_first = 1'b0; start = 1'b1; read_sig = 1'b1; din1 = 1'b1;
        step();
        start = 1'b0; read_sig = 1'b0;
        strobe1(1'b0);
        strobe1(1'b1);
        wait_idle("start_strobe_idle");

        chk_b = 1'b1;
        din1 = 1'b0;
        qb.push_back('{32'hA5, 6'd8, 1'b0});
        qa.push_back('{32'h0, 6'd2, 1'b0});
        begin_frame(6'd2, 1'b0);
        read_sig = 1'b1; din1 = 1'b0; din4 = 4'hA;
        step();
        din4 = 4'h5;
        step();
        read_sig = 1'b0;
        wait_idle("lanes_msb_idle");
        chk("lanes_ready", 32'(rdy_b), 32'd1);
        qb.push_back('{32'hC1, 6'd8, 1'b0});
        qa.push_back('{32'h0, 6'd2, 1'b0});
        begin_frame(6'd2, 1'b1);
        read_sig = 1'b1; din4 = 4'b1000;
        step();
        din4 = 4'b0011;
        step();
        read_sig = 1'b0;
        wait_idle("lanes_lsb_idle");
        step();
        chk_b = 1'b0;

`ifdef READER_TIMEOUT_EN
        qa.push_back('{32'h6, 6'd3, 1'b1});
        begin_frame(6'd8, 1'b0);
        strobe1(1'b1);
        strobe1(1'b1);
        strobe1(1'b0);
        repeat (16) step();
        chk("tmo_early", 32'(done_a), 32'd0);
        step();
        chk("tmo_done", {done_a, to_a, rdy_a}, 32'b111);
        wait_idle("tmo_idle");
`else
        begin_frame(6'd8, 1'b0);
        strobe1(1'b1);
        strobe1(1'b1);
        strobe1(1'b0);
        repeat (1000) step();
        chk("no_tmo_flags", {busy_a, rdy_a, to_a}, 32'b100);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("no_tmo_abort", 32'(busy_a), 32'd0);
`endif

        repeat (3) step();
        chk("qa_empty", qa.size(), 32'd0);
        chk("qb_empty", qb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
